// File: rtl/mem_arbiter.sv
// Two-port line arbiter: an instruction-side read port and a data-side
// read/write port share one physical memory. Only one transaction is in
// flight at a time. The D side has priority, but it can win only
// MAX_D_STREAK times in a row while the I side is waiting.
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | no transaction in flight; arbitrate and latch on grant
// I_BUSY | I-side line read issued, waiting for pmem_resp
// D_BUSY | D-side line read or write issued, waiting for pmem_resp

module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [STREAK_W-1:0]   streak, streak_nxt;
    logic                  lat_write, lat_write_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
    logic [LINE_WIDTH-1:0] lat_wdata, lat_wdata_nxt;
    logic                  busy;
    logic                  i_starved;

    // State, streak counter and the latched transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            streak    <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            lat_write <= lat_write_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
        end
    end

    // Arbitration, latching on grant, and completion detection.
    always_comb begin
        state_nxt     = state;
        streak_nxt    = streak;
        lat_write_nxt = lat_write;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        i_resp        = 1'b0;
        d_resp        = 1'b0;
        i_starved     = i_read && (streak == STREAK_MAX);

        case (state)
            IDLE: begin
                if ((d_read || d_write) && !i_starved) begin
                    state_nxt     = D_BUSY;
                    // A simultaneous read and write request is a write.
                    lat_write_nxt = d_write;
                    lat_addr_nxt  = d_address;
                    lat_wdata_nxt = d_wdata;
                    // The streak only counts D wins that kept the I side waiting.
                    if (i_read) begin
                        streak_nxt = (streak == STREAK_MAX) ? streak : streak + 1'b1;
                    end else begin
                        streak_nxt = '0;
                    end
                end else if (i_read) begin
                    state_nxt     = I_BUSY;
                    lat_write_nxt = 1'b0;
                    lat_addr_nxt  = i_address;
                    lat_wdata_nxt = '0;
                    streak_nxt    = '0;
                end
            end
            I_BUSY: begin
                if (pmem_resp) begin
                    i_resp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            D_BUSY: begin
                if (pmem_resp) begin
                    d_resp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The memory request comes only from the latched copy, so requesters may
    // change their inputs freely once they have been granted.
    always_comb begin
        busy         = (state != IDLE);
        pmem_read    = busy && !lat_write;
        pmem_write   = busy && lat_write;
        pmem_address = busy ? lat_addr : '0;
        pmem_wdata   = busy ? lat_wdata : '0;
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Each expected memory transaction is pushed
// to a scoreboard queue when its stimulus is driven. It is popped and
// compared when the arbiter issues to memory, and again when the response
// returns to one of the two sides.

module tb_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    typedef struct {
        logic         side_d;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_wait = 0;

    mem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .MAX_D_STREAK(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic side_d, input logic wr,
                        input logic [15:0] addr, input logic [127:0] wdata);
        txn_t t;
        t.side_d = side_d;
        t.wr     = wr;
        t.addr   = addr;
        t.wdata  = wdata;
        sb.push_back(t);
    endtask

    // Wait (bounded) for the next memory request, check it against the
    // scoreboard, respond after lat busy cycles and check the response routing.
    task automatic serve(input int lat, input logic [127:0] rdata);
        txn_t e;
        int   n;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            cyc();
            n++;
        end
        last_wait = n;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: request observed with no expected transaction");
            return;
        end
        e = sb.pop_front();
        chk("issue_seen", pmem_read | pmem_write, 1'b1);
        chk("pmem_write", pmem_write, e.wr);
        chk("pmem_read", pmem_read, !e.wr);
        chk("pmem_address", pmem_address, e.addr);
        if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
        repeat (lat - 1) cyc();
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        #1;
        chk("i_resp", i_resp, !e.side_d);
        chk("d_resp", d_resp, e.side_d);
        if (e.side_d) chk("d_rdata", d_rdata, rdata);
        else          chk("i_rdata", i_rdata, rdata);
        cyc();
        pmem_resp = 1'b0;
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] w1;
        logic [127:0] w2;
        logic [127:0] stray;
        a5    = {16{8'hA5}};
        w1    = {8{16'h1234}};
        w2    = {4{32'hDEAD_BEEF}};
        stray = {4{32'h0BAD_F00D}};

        rst_n = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // Reset state
        #3;
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);
        chk("rst_pmem_address", pmem_address, 16'h0);
        chk("rst_pmem_wdata", pmem_wdata, 128'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Stray pmem_resp while idle is ignored; rdata still passes through
        cyc();
        pmem_resp = 1'b1; pmem_rdata = stray;
        #1;
        chk("idle_i_resp", i_resp, 1'b0);
        chk("idle_d_resp", d_resp, 1'b0);
        chk("idle_i_rdata_pass", i_rdata, stray);
        chk("idle_d_rdata_pass", d_rdata, stray);
        cyc();
        pmem_resp = 1'b0;
        #1;
        chk("idle_stays_read", pmem_read, 1'b0);
        chk("idle_stays_write", pmem_write, 1'b0);

        // Lone I read: request reaches memory one cycle later
        cyc();
        i_read = 1'b1; i_address = 16'h0040;
        push(1'b0, 1'b0, 16'h0040, '0);
        #1;
        chk("lone_no_early_issue", pmem_read, 1'b0);
        serve(3, a5);
        chk("lone_issue_latency", last_wait, 1);
        i_read = 1'b0;

        // Simultaneous I read and D write: D first, one idle cycle, then I
        cyc();
        i_read = 1'b1; i_address = 16'h0080;
        d_write = 1'b1; d_address = 16'h1000; d_wdata = w1;
        push(1'b1, 1'b1, 16'h1000, w1);
        push(1'b0, 1'b0, 16'h0080, '0);
        serve(2, w2);
        d_write = 1'b0;
        serve(2, a5);
        chk("sim_idle_gap", last_wait, 1);
        i_read = 1'b0;

        // Streak: three D wins, a D win with I idle clears, then four D wins and I
        cyc();
        i_read = 1'b1; i_address = 16'h0100;
        d_read = 1'b1; d_address = 16'h0200;
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 1'b0, 16'h0200, '0);
            serve(1, 128'(k));
        end
        i_read = 1'b0;
        push(1'b1, 1'b0, 16'h0200, '0);
        serve(1, 128'h55);
        i_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(1'b1, 1'b0, 16'h0200, '0);
            serve(2, 128'(k + 16));
        end
        push(1'b0, 1'b0, 16'h0100, '0);
        serve(2, a5);
        i_read = 1'b0;
        push(1'b1, 1'b0, 16'h0200, '0);
        serve(1, 128'h77);
        d_read = 1'b0;

        // Requester changes its inputs mid-transaction
        cyc();
        d_read = 1'b1; d_address = 16'h2000;
        cyc();
        chk("mid_issue_read", pmem_read, 1'b1);
        chk("mid_issue_addr", pmem_address, 16'h2000);
        d_address = 16'h3000; d_read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("mid_hold_addr", pmem_address, 16'h2000);
            chk("mid_hold_read", pmem_read, 1'b1);
        end
        pmem_resp = 1'b1; pmem_rdata = w2;
        #1;
        chk("mid_d_resp", d_resp, 1'b1);
        chk("mid_i_resp", i_resp, 1'b0);
        chk("mid_d_rdata", d_rdata, w2);
        cyc();
        pmem_resp = 1'b0;
        cyc();
        chk("mid_back_idle", pmem_read, 1'b0);

        // d_read and d_write together is a write
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h0010; d_wdata = w2;
        push(1'b1, 1'b1, 16'h0010, w2);
        serve(1, a5);
        d_read = 1'b0; d_write = 1'b0;

        // Reset during I_BUSY abandons the transaction asynchronously
        cyc();
        i_read = 1'b1; i_address = 16'h0440;
        cyc();
        chk("rbusy_read", pmem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk("rasync_pmem_read", pmem_read, 1'b0);
        chk("rasync_pmem_address", pmem_address, 16'h0);
        chk("rasync_i_resp", i_resp, 1'b0);
        chk("rasync_d_resp", d_resp, 1'b0);
        i_read = 1'b0;
        pmem_resp = 1'b0;
        cyc();
        rst_n = 1'b1;
        pmem_resp = 1'b1;
        #1;
        chk("rstray_i_resp", i_resp, 1'b0);
        chk("rstray_d_resp", d_resp, 1'b0);
        cyc();
        pmem_resp = 1'b0;
        #1;
        chk("rstray_idle", pmem_read | pmem_write, 1'b0);

        // Normal operation after the reset
        cyc();
        d_write = 1'b1; d_address = 16'h0800; d_wdata = w1;
        push(1'b1, 1'b1, 16'h0800, w1);
        serve(2, a5);
        d_write = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory byte address width.
REQ-002 Parameter LINE_WIDTH, default 128, width of one cache line transferred per transaction.
REQ-003 Parameter MAX_D_STREAK, default 4, consecutive D-side grants allowed while I-side waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_read  input  1  instruction-side line read request, level, held until i_resp.
REQ-007 i_address  input  ADDR_WIDTH  instruction-side line address.
REQ-008 i_rdata  output  LINE_WIDTH  line returned to instruction side.
REQ-009 i_resp  output  1  one-cycle completion pulse to instruction side.
REQ-010 d_read  input  1  data-side line read request, level.
REQ-011 d_write  input  1  data-side line write request, level.
REQ-012 d_address  input  ADDR_WIDTH  data-side line address.
REQ-013 d_wdata  input  LINE_WIDTH  data-side write line.
REQ-014 d_rdata  output  LINE_WIDTH  line returned to data side.
REQ-015 d_resp  output  1  one-cycle completion pulse to data side.
REQ-016 pmem_read / pmem_write  output  1 each  request to shared physical memory.
REQ-017 pmem_address  output  ADDR_WIDTH; pmem_wdata  output  LINE_WIDTH.
REQ-018 pmem_rdata  input  LINE_WIDTH; pmem_resp  input  1  completion pulse from memory.

Function
REQ-019 FSM states SHALL be IDLE, I_BUSY, D_BUSY; exactly one transaction outstanding at a time.
REQ-020 In IDLE with no request, state SHALL remain IDLE and pmem_read, pmem_write, i_resp, d_resp SHALL be 0.
REQ-021 In IDLE, grant SHALL go to D-side when (d_read|d_write) and not (i_read and streak==MAX_D_STREAK); else to I-side if i_read.
REQ-022 At the granting edge the arbiter SHALL latch address, wdata and op (write if d_write, else read) into internal registers; d_read and d_write both high SHALL be treated as write.
REQ-023 pmem_read/pmem_write/pmem_address/pmem_wdata SHALL be driven solely from latched registers in I_BUSY/D_BUSY; request-to-pmem latency exactly 1 cycle after request first seen in IDLE.
REQ-024 Requester inputs changing or dropping during BUSY SHALL NOT affect the outstanding transaction.
REQ-025 In X_BUSY with pmem_resp=1, arbiter SHALL assert X_resp combinationally that cycle, pass pmem_rdata to X_rdata, and move to IDLE at next edge.
REQ-026 pmem_resp in IDLE SHALL be ignored; the non-granted side's resp SHALL never assert.
REQ-027 i_rdata and d_rdata SHALL equal pmem_rdata at all times (valid only with their resp).
REQ-028 At least one IDLE cycle SHALL separate consecutive transactions; back-to-back requester sees resp-to-next-resp ≥ 2 cycles + memory latency.
REQ-029 streak counter ($clog2(MAX_D_STREAK+1) bits): on D grant with i_read=1, increment (saturate at MAX_D_STREAK); on D grant with i_read=0, clear; on I grant, clear.
REQ-030 A transaction with no pmem_resp SHALL hold BUSY indefinitely; no timeout.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, streak 0, latched op/address/wdata 0, and all outputs 0 (pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata), regardless of clk.
REQ-032 Reset during BUSY SHALL abandon the transaction; a pmem_resp arriving after reset release while IDLE SHALL be ignored.
REQ-033 First grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-034 Lone I read: i_read=1, i_address=0x0040, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1, pmem_address=0x0040 one cycle after request; i_resp one cycle with i_rdata=0xA5..A5; d_resp stays 0.
REQ-035 Simultaneous: i_read and d_write (addr 0x1000, wdata 0x1234..) same cycle -> D granted first (pmem_write=1, addr 0x1000); after d_resp, one IDLE cycle, then I read issued.
REQ-036 Starvation: MAX_D_STREAK=4, i_read held, D requests continuously -> exactly 4 D grants, then I granted, streak cleared, D resumes.
REQ-037 Mid-transaction change: after D read grant at 0x2000, change d_address to 0x3000 and drop d_read -> pmem_address stays 0x2000 until pmem_resp; d_resp still pulses.
REQ-038 Reset mid-op: rst_n low during I_BUSY -> all outputs 0 asynchronously; stray pmem_resp after release produces no i_resp/d_resp.
REQ-039 d_read and d_write both high at 0x0010 -> pmem_write=1, pmem_read=0.
